// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle for cache_refill_ctrl: CPU load port, cache array lookup/fill
// port and word-wide memory read port.
//   master : the refill controller side
//   slave  : the CPU / cache array / memory side
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic [ADDR_WIDTH-1:0] cache_addr;
    logic                  cache_hit;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic                  fill_we;
    logic [DATA_WIDTH-1:0] fill_d0;
    logic [DATA_WIDTH-1:0] fill_d1;
    logic [DATA_WIDTH-1:0] fill_d2;
    logic [DATA_WIDTH-1:0] fill_d3;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
        output cpu_stall, cpu_rdata, cache_addr, fill_we,
               fill_d0, fill_d1, fill_d2, fill_d3, mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
        input  cpu_stall, cpu_rdata, cache_addr, fill_we,
               fill_d0, fill_d1, fill_d2, fill_d3, mem_req, mem_addr
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss/refill sequencer for a direct-mapped read cache with 4-word blocks.
// Hits return cache data with no stall; a miss stalls the CPU, fetches the
// block word by word (order 0..3) from memory, installs it in one fill cycle
// and lets the following lookup hit. Saturating hit/miss counters included.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   bus          cache_refill_ctrl_if.master (CPU, cache array, memory)
//   busy         controller is refilling (state != IDLE)
//   hit_count    saturating count of hit cycles
//   miss_count   saturating count of misses
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lookup cpu_addr; hit returns data, miss captures address
// FETCH | request block word cnt from memory, buffer it on mem_ack
// FILL  | write buffered block into the cache set of miss_addr
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_ctrl_if.master  bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            cnt;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic [DATA_WIDTH-1:0] line_buf [4];

    logic idle_hit;
    logic idle_miss;

    assign idle_hit  = (state == ST_IDLE) && bus.cpu_req && bus.cache_hit;
    assign idle_miss = (state == ST_IDLE) && bus.cpu_req && !bus.cache_hit;
    assign busy      = (state != ST_IDLE);

    assign bus.fill_d0 = line_buf[0];
    assign bus.fill_d1 = line_buf[1];
    assign bus.fill_d2 = line_buf[2];
    assign bus.fill_d3 = line_buf[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.cpu_stall  = 1'b0;
        bus.cpu_rdata  = bus.cache_rdata;
        bus.cache_addr = bus.cpu_addr;
        bus.fill_we    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_addr   = {miss_addr[ADDR_WIDTH-1:4], cnt, 2'b00};
        case (state)
            ST_IDLE: begin
                if (idle_miss) begin
                    bus.cpu_stall = 1'b1;
                    state_next    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                bus.cpu_stall  = 1'b1;
                bus.cache_addr = miss_addr;
                bus.mem_req    = 1'b1;
                if (bus.mem_ack && (cnt == 2'd3)) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                bus.cpu_stall  = 1'b1;
                bus.cache_addr = miss_addr;
                bus.fill_we    = 1'b1;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: miss capture, word buffering and counters. A reset mid-refill
    // discards the partial block; the fill only ever comes from ST_FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 2'd0;
            miss_addr  <= '0;
            line_buf   <= '{default: '0};
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (idle_hit && (hit_count != {CNT_WIDTH{1'b1}})) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (idle_miss) begin
                miss_addr <= bus.cpu_addr;
                cnt       <= 2'd0;
                if (miss_count != {CNT_WIDTH{1'b1}}) begin
                    miss_count <= miss_count + CNT_WIDTH'(1);
                end
            end
            // cnt wraps 3 -> 0 on the last ack, ready for the next miss.
            if ((state == ST_FETCH) && bus.mem_ack) begin
                line_buf[cnt] <= bus.mem_rdata;
                cnt           <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: behavioural direct-mapped cache
// (16 sets, index addr[7:4], tag addr[31:8]) and a memory that acks each
// word on the third cycle of its request. A second instance with a 4-bit
// counter covers hit counter saturation.
module tb_cache_refill_ctrl;
    logic clk;
    logic rst;

    cache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    cache_refill_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus4 ();

    logic        busy;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
    logic        busy4;
    logic [3:0]  hit_count4;
    logic [3:0]  miss_count4;

    cache_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .busy(busy4), .hit_count(hit_count4), .miss_count(miss_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1) return 32'hA0 + {30'd0, a[3:2]};
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- cache array model ----------------
    logic        preload;
    logic [15:0] c_valid;
    logic [23:0] c_tag  [16];
    logic [31:0] c_data [16][4];
    logic [3:0]  c_idx;

    assign c_idx             = bus.cache_addr[7:4];
    assign bus.cache_hit     = c_valid[c_idx] && (c_tag[c_idx] == bus.cache_addr[31:8]);
    assign bus.cache_rdata   = c_data[c_idx][bus.cache_addr[3:2]];

    always @(posedge clk) begin
        if (rst) begin
            c_valid <= '0;
        end else if (preload) begin
            c_valid[0] <= 1'b1;
            c_tag[0]   <= 24'h1;
            for (int w = 0; w < 4; w++) c_data[0][w] <= 32'h1111_0100 + w * 4;
        end else if (bus.fill_we) begin
            c_valid[c_idx]    <= 1'b1;
            c_tag[c_idx]      <= bus.cache_addr[31:8];
            c_data[c_idx][0]  <= bus.fill_d0;
            c_data[c_idx][1]  <= bus.fill_d1;
            c_data[c_idx][2]  <= bus.fill_d2;
            c_data[c_idx][3]  <= bus.fill_d3;
        end
    end

    // ---------------- memory model ----------------
    logic model_ack = 1'b0;
    logic stray_ack;
    int   mem_wait  = 0;

    assign bus.mem_ack   = model_ack | stray_ack;
    assign bus.mem_rdata = mem_word(bus.mem_addr);

    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (model_ack) begin
                model_ack = 1'b0;
                mem_wait  = 1;
            end else if (mem_wait == 2) begin
                model_ack = 1'b1;
            end else begin
                mem_wait++;
            end
        end else begin
            model_ack = 1'b0;
            mem_wait  = 0;
        end
    end

    // ---------------- monitors ----------------
    int          ack_n  = 0;
    int          fill_n = 0;
    logic [31:0] ack_log [64];
    logic [31:0] fd [4];

    always @(posedge clk) begin
        if (!rst && bus.mem_req && bus.mem_ack) begin
            if (ack_n < 64) ack_log[ack_n] = bus.mem_addr;
            ack_n++;
        end
        if (!rst && bus.fill_we) begin
            fill_n++;
            fd[0] = bus.fill_d0;
            fd[1] = bus.fill_d1;
            fd[2] = bus.fill_d2;
            fd[3] = bus.fill_d3;
        end
    end

    // ---------------- second instance stimulus ----------------
    logic req4;
    assign bus4.cpu_req     = req4;
    assign bus4.cpu_addr    = 32'h40;
    assign bus4.cache_hit   = 1'b1;
    assign bus4.cache_rdata = 32'h0;
    assign bus4.mem_ack     = 1'b0;
    assign bus4.mem_rdata   = 32'h0;

    // Issue a request and wait (bounded) until the stall drops; returns the
    // number of stalled cycles. Leaves cpu_req asserted in the hit cycle.
    task automatic do_miss(input logic [31:0] addr, output int cycles);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        #1;
        cycles = 0;
        while (bus.cpu_stall && cycles < 200) begin
            cycles++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic release_req();
        @(negedge clk);
        bus.cpu_req = 1'b0;
        #1;
    endtask

    int cyc;
    int base_ack;
    int base_fill;
    int guard;

    initial begin
        rst          = 1'b1;
        preload      = 1'b0;
        stray_ack    = 1'b0;
        req4         = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = 32'h104;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_fill_we", bus.fill_we, 0);
        check("rst_fill_d0", bus.fill_d0, 0);
        check("rst_cache_addr", bus.cache_addr, 32'h104);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);

        @(negedge clk);
        rst     = 1'b0;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;

        // 1: hit at 0x104, zero-latency data
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h104;
        #1;
        check("t1_stall", bus.cpu_stall, 0);
        check("t1_rdata", bus.cpu_rdata, 32'h1111_0104);
        release_req();
        check("t1_hits", hit_count, 1);
        check("t1_misses", miss_count, 0);

        // 2: miss at 0x14, words A0..A3
        base_ack  = ack_n;
        base_fill = fill_n;
        do_miss(32'h14, cyc);
        check("t2_stall_len", cyc, 14);
        check("t2_rdata", bus.cpu_rdata, 32'hA1);
        check("t2_misses", miss_count, 1);
        check("t2_acks", ack_n - base_ack, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_mem_addr%0d", i), ack_log[base_ack + i], 32'h10 + i * 4);
            check($sformatf("t2_fill_d%0d", i), fd[i], 32'hA0 + i);
        end
        check("t2_fills", fill_n - base_fill, 1);
        release_req();
        check("t2_hits", hit_count, 2);

        // 3: reset after the second ack of a refill
        base_ack  = ack_n;
        base_fill = fill_n;
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h314;
        guard = 0;
        while ((ack_n - base_ack) < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("t3_acks_before_rst", ack_n - base_ack, 2);
        rst         = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        #1;
        check("t3_busy", busy, 0);
        check("t3_mem_req", bus.mem_req, 0);
        check("t3_hits", hit_count, 0);
        check("t3_misses", miss_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("t3_no_fill", fill_n - base_fill, 0);
        check("t3_idle", busy, 0);

        // 4: two misses to set 1 with different tags, then the first again
        base_fill = fill_n;
        do_miss(32'h010, cyc);
        check("t4a_stall_len", cyc, 14);
        check("t4a_rdata", bus.cpu_rdata, 32'hA0);
        release_req();
        do_miss(32'h210, cyc);
        check("t4b_stall_len", cyc, 14);
        check("t4b_rdata", bus.cpu_rdata, 32'h5A5A_0210);
        check("t4b_fill_d0", fd[0], 32'h5A5A_0210);
        check("t4b_fill_d3", fd[3], 32'h5A5A_021C);
        check("t4b_misses", miss_count, 2);
        release_req();
        do_miss(32'h018, cyc);
        check("t4c_refetch_len", cyc, 14);
        check("t4c_rdata", bus.cpu_rdata, 32'hA2);
        release_req();
        check("t4_fills", fill_n - base_fill, 3);
        check("t4_misses", miss_count, 3);
        check("t4_hits", hit_count, 3);

        // 5: 4-bit hit counter saturation
        @(negedge clk);
        req4 = 1'b1;
        repeat (14) @(negedge clk);
        #1;
        check("t5_hits14", hit_count4, 4'hE);
        repeat (6) @(negedge clk);
        req4 = 1'b0;
        #1;
        check("t5_hits_sat", hit_count4, 4'hF);
        check("t5_misses", miss_count4, 0);

        // 6: stray ack in IDLE, then cpu_req dropped mid-FETCH
        base_ack  = ack_n;
        base_fill = fill_n;
        @(negedge clk);
        stray_ack = 1'b1;
        #1;
        check("t6_stray_busy", busy, 0);
        @(negedge clk);
        stray_ack = 1'b0;
        #1;
        check("t6_stray_idle", busy, 0);
        check("t6_stray_mem_req", bus.mem_req, 0);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h514;
        guard = 0;
        while ((ack_n - base_ack) < 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.cpu_req = 1'b0;
        guard = 0;
        #1;
        while (busy && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("t6_busy_done", busy, 0);
        check("t6_acks", ack_n - base_ack, 4);
        check("t6_fills", fill_n - base_fill, 1);
        check("t6_fill_d0", fd[0], 32'h5A5A_0510);
        check("t6_misses", miss_count, 4);
        check("t6_hits", hit_count, 3);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h518;
        #1;
        check("t6_installed_stall", bus.cpu_stall, 0);
        check("t6_installed_rdata", bus.cpu_rdata, 32'h5A5A_0518);
        release_req();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
